iss_ex_stage: RTL and testbench
===============================

ISS_EX_STAGE -- requirements
Module: iss_ex_stage

Interface
REQ-001 clk  in  1  sole clock, rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 valid_iss_i, rs_iss_i/rt_iss_i/rd_iss_i  in  1/5/5/5  issue-stage instruction valid, source/dest register numbers.
REQ-004 rs_data_iss_i, rt_data_iss_i, imm_iss_i  in  32 each  regfile operands, sign-extended immediate.
REQ-005 alu_op_iss_i  in  4; alu_src_iss_i, mem_to_reg_iss_i, mem_wr_iss_i, reg_wr_iss_i  in  1 each  decoded controls.
REQ-006 flush_ex_hz_i, stall_ex_hz_i  in  1 each  hazard-unit bubble request, EX hold request.
REQ-007 fwd_p1_hz_i, fwd_p2_hz_i  in  2 each  forward selects for rs / rt operand.
REQ-008 alu_res_mem_i, wr_data_wb_i  in  32 each  MEM-stage ALU result, WB write data.
REQ-009 valid_ex_o, rs_ex_hz_o, rt_ex_hz_o, rd_ex_o  out  1/5/5/5  EX instruction fields; rs/rt feed hazard unit.
REQ-010 mem_to_reg_ex_hz_o, reg_wr_ex_o, mem_wr_ex_o, alu_op_ex_o  out  1/1/1/4  EX controls.
REQ-011 op1_ex_o, op2_ex_o, store_data_ex_o  out  32 each  forwarded ALU operands, forwarded rt store data.
REQ-012 bubble_cnt_o, stall_cnt_o  out  32 each  performance counters (see Configuration).

Function
REQ-013 Per rising edge, priority: flush_ex_hz_i > stall_ex_hz_i > load.
REQ-014 Flush: valid, reg_wr, mem_wr, mem_to_reg regs cleared next edge; data/register-number fields don't-care; flush during stall ends the stall.
REQ-015 Load: all EX registers capture issue inputs next edge; valid_ex_o = valid_iss_i; 1-cycle latency.
REQ-016 Stall: all EX registers hold, except operand capture per REQ-018.
REQ-017 Forward select encoding: 00 register value, 01 wr_data_wb_i, 10 alu_res_mem_i, 11 treated as 00.
REQ-018 First stall cycle (stall high, capt flag low): stored rs/rt data overwritten with forwarded values, capt flag set; later stall cycles ignore fwd selects; capt flag cleared on any load or flush.
REQ-019 While capt flag set, fwd mux selection forced to 00.
REQ-020 op1_ex_o = forwarded rs; op2_ex_o = imm when alu_src=1 else forwarded rt; store_data_ex_o = forwarded rt; all combinational from EX regs and forward inputs.
REQ-021 When valid_ex_o=0, reg_wr_ex_o, mem_wr_ex_o, mem_to_reg_ex_hz_o read 0.
REQ-022 rs_ex_hz_o/rt_ex_hz_o driven directly from EX registers, no combinational path from issue inputs.

Reset
REQ-023 rst_n low: all EX registers, capt flag, counters to 0 immediately; all outputs 0 (op2_ex_o 0 since imm reg 0).
REQ-024 First edge after rst_n release performs a normal load.

Configuration
REQ-025 Macro ISS_EX_PERF_CNT_EN defined: bubble_cnt_o increments on each flush edge, stall_cnt_o on each stall edge without flush; both wrap 0xFFFFFFFF->0.
REQ-026 Macro undefined: no counter flops; both outputs tied 0; all other behaviour identical.

Structure
REQ-027 Shared package mips_pipe_pkg holds forward-select constants (FWD_REG, FWD_WB, FWD_MEM), ALU-op width, data width 32.
REQ-028 One sub-module fwd_mux (3:1, 32-bit, 11->register), instantiated twice.

Verification
REQ-029 Load add rs=3 (0x10), rt=4 (0x20), fwd 00/00 -> next cycle valid_ex_o=1, op1=0x10, op2=0x20, rs_ex_hz_o=3.
REQ-030 EX holds rs=5, fwd_p1=10, alu_res_mem_i=0xDEAD -> op1=0xDEAD; fwd_p2=01, wr_data_wb_i=0xBEEF, alu_src=0 -> op2=store_data=0xBEEF.
REQ-031 fwd_p1=10, mem=0x55, stall 3 cycles, mem changes to 0x99 after cycle 1 -> op1 stays 0x55 all stall cycles.
REQ-032 flush and stall together with reg_wr=1 -> next cycle valid_ex_o=0, reg_wr_ex_o=0; with macro, bubble_cnt_o+1, stall_cnt_o unchanged.
REQ-033 rst_n low mid-stall -> outputs 0 without clock edge; after release first edge loads issue inputs.
REQ-034 Macro on, stall_cnt preloaded 0xFFFFFFFF by force, one stall -> 0; macro off -> both counters 0 throughout.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: data/ALU-op widths and forward-select encodings.
package mips_pipe_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ALU_OP_W   = 4;
    localparam int unsigned REG_ADDR_W = 5;

    // Forward-select encodings; 2'b11 is reserved and behaves like FWD_REG.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Decoded control bits carried alongside an instruction.
    typedef struct packed {
        logic alu_src;
        logic mem_to_reg;
        logic mem_wr;
        logic reg_wr;
    } ex_ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// 3:1 operand forwarding mux; the reserved select value picks the register operand.
module fwd_mux
    import mips_pipe_pkg::*;
(
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] data_o
);

    // Select the operand source.
    always_comb begin
        data_o = reg_data_i;
        case (sel_i)
            FWD_WB:  data_o = wb_data_i;
            FWD_MEM: data_o = mem_data_i;
            default: data_o = reg_data_i;
        endcase
    end

endmodule

// File: rtl/iss_ex_stage.sv
// Issue -> EX pipeline register with operand forwarding.
// Stall holds the instruction but freezes the forwarded operands on the first
// stall cycle, since MEM/WB will move on while EX is held.
// Optional performance counters are built when ISS_EX_PERF_CNT_EN is defined.
module iss_ex_stage
    import mips_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  valid_iss_i,
    input  logic [REG_ADDR_W-1:0] rs_iss_i,
    input  logic [REG_ADDR_W-1:0] rt_iss_i,
    input  logic [REG_ADDR_W-1:0] rd_iss_i,
    input  logic [DATA_W-1:0]     rs_data_iss_i,
    input  logic [DATA_W-1:0]     rt_data_iss_i,
    input  logic [DATA_W-1:0]     imm_iss_i,
    input  logic [ALU_OP_W-1:0]   alu_op_iss_i,
    input  logic                  alu_src_iss_i,
    input  logic                  mem_to_reg_iss_i,
    input  logic                  mem_wr_iss_i,
    input  logic                  reg_wr_iss_i,

    input  logic                  flush_ex_hz_i,
    input  logic                  stall_ex_hz_i,
    input  logic [1:0]            fwd_p1_hz_i,
    input  logic [1:0]            fwd_p2_hz_i,
    input  logic [DATA_W-1:0]     alu_res_mem_i,
    input  logic [DATA_W-1:0]     wr_data_wb_i,

    output logic                  valid_ex_o,
    output logic [REG_ADDR_W-1:0] rs_ex_hz_o,
    output logic [REG_ADDR_W-1:0] rt_ex_hz_o,
    output logic [REG_ADDR_W-1:0] rd_ex_o,
    output logic                  mem_to_reg_ex_hz_o,
    output logic                  reg_wr_ex_o,
    output logic                  mem_wr_ex_o,
    output logic [ALU_OP_W-1:0]   alu_op_ex_o,
    output logic [DATA_W-1:0]     op1_ex_o,
    output logic [DATA_W-1:0]     op2_ex_o,
    output logic [DATA_W-1:0]     store_data_ex_o,
    output logic [DATA_W-1:0]     bubble_cnt_o,
    output logic [DATA_W-1:0]     stall_cnt_o
);

    logic                  valid_q;
    logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
    logic [DATA_W-1:0]     rs_data_q, rt_data_q, imm_q;
    logic [ALU_OP_W-1:0]   alu_op_q;
    ex_ctrl_t              ctrl_q;
    logic                  capt_q;

    logic [1:0]            sel_p1, sel_p2;
    logic [DATA_W-1:0]     fwd_rs, fwd_rt;

    // Once operands are captured, the stored values are already the forwarded ones.
    always_comb begin
        sel_p1 = capt_q ? FWD_REG : fwd_p1_hz_i;
        sel_p2 = capt_q ? FWD_REG : fwd_p2_hz_i;
    end

    fwd_mux u_fwd_rs (
        .sel_i      (sel_p1),
        .reg_data_i (rs_data_q),
        .wb_data_i  (wr_data_wb_i),
        .mem_data_i (alu_res_mem_i),
        .data_o     (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .sel_i      (sel_p2),
        .reg_data_i (rt_data_q),
        .wb_data_i  (wr_data_wb_i),
        .mem_data_i (alu_res_mem_i),
        .data_o     (fwd_rt)
    );

    // EX pipeline register: flush > stall (with one-shot operand capture) > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            alu_op_q  <= '0;
            ctrl_q    <= '0;
            capt_q    <= 1'b0;
        end else if (flush_ex_hz_i) begin
            // Data fields are left as-is; only the bits that make the slot live are cleared.
            valid_q           <= 1'b0;
            ctrl_q.reg_wr     <= 1'b0;
            ctrl_q.mem_wr     <= 1'b0;
            ctrl_q.mem_to_reg <= 1'b0;
            capt_q            <= 1'b0;
        end else if (stall_ex_hz_i) begin
            if (!capt_q) begin
                rs_data_q <= fwd_rs;
                rt_data_q <= fwd_rt;
                capt_q    <= 1'b1;
            end
        end else begin
            valid_q           <= valid_iss_i;
            rs_q              <= rs_iss_i;
            rt_q              <= rt_iss_i;
            rd_q              <= rd_iss_i;
            rs_data_q         <= rs_data_iss_i;
            rt_data_q         <= rt_data_iss_i;
            imm_q             <= imm_iss_i;
            alu_op_q          <= alu_op_iss_i;
            ctrl_q.alu_src    <= alu_src_iss_i;
            ctrl_q.mem_to_reg <= mem_to_reg_iss_i;
            ctrl_q.mem_wr     <= mem_wr_iss_i;
            ctrl_q.reg_wr     <= reg_wr_iss_i;
            capt_q            <= 1'b0;
        end
    end

    // Outputs: register fields, valid-qualified controls, forwarded operands.
    always_comb begin
        valid_ex_o         = valid_q;
        rs_ex_hz_o         = rs_q;
        rt_ex_hz_o         = rt_q;
        rd_ex_o            = rd_q;
        alu_op_ex_o        = alu_op_q;
        mem_to_reg_ex_hz_o = valid_q & ctrl_q.mem_to_reg;
        reg_wr_ex_o        = valid_q & ctrl_q.reg_wr;
        mem_wr_ex_o        = valid_q & ctrl_q.mem_wr;
        op1_ex_o           = fwd_rs;
        op2_ex_o           = ctrl_q.alu_src ? imm_q : fwd_rt;
        store_data_ex_o    = fwd_rt;
    end

`ifdef ISS_EX_PERF_CNT_EN
    logic [DATA_W-1:0] bubble_cnt_q, stall_cnt_q;

    // Bubble counts flush edges; stall counts stall edges not overridden by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else if (flush_ex_hz_i) begin
            bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end else if (stall_ex_hz_i) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`else
    assign bubble_cnt_o = '0;
    assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_iss_ex_stage.sv
// Directed, table-driven bench for iss_ex_stage plus stall/flush/reset sequences.
module tb_iss_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_iss_i;
    logic [4:0]  rs_iss_i, rt_iss_i, rd_iss_i;
    logic [31:0] rs_data_iss_i, rt_data_iss_i, imm_iss_i;
    logic [3:0]  alu_op_iss_i;
    logic        alu_src_iss_i, mem_to_reg_iss_i, mem_wr_iss_i, reg_wr_iss_i;
    logic        flush_ex_hz_i, stall_ex_hz_i;
    logic [1:0]  fwd_p1_hz_i, fwd_p2_hz_i;
    logic [31:0] alu_res_mem_i, wr_data_wb_i;
    logic        valid_ex_o;
    logic [4:0]  rs_ex_hz_o, rt_ex_hz_o, rd_ex_o;
    logic        mem_to_reg_ex_hz_o, reg_wr_ex_o, mem_wr_ex_o;
    logic [3:0]  alu_op_ex_o;
    logic [31:0] op1_ex_o, op2_ex_o, store_data_ex_o, bubble_cnt_o, stall_cnt_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_bubble = 0;
    logic [31:0] exp_stall  = 0;

    iss_ex_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .valid_iss_i        (valid_iss_i),
        .rs_iss_i           (rs_iss_i),
        .rt_iss_i           (rt_iss_i),
        .rd_iss_i           (rd_iss_i),
        .rs_data_iss_i      (rs_data_iss_i),
        .rt_data_iss_i      (rt_data_iss_i),
        .imm_iss_i          (imm_iss_i),
        .alu_op_iss_i       (alu_op_iss_i),
        .alu_src_iss_i      (alu_src_iss_i),
        .mem_to_reg_iss_i   (mem_to_reg_iss_i),
        .mem_wr_iss_i       (mem_wr_iss_i),
        .reg_wr_iss_i       (reg_wr_iss_i),
        .flush_ex_hz_i      (flush_ex_hz_i),
        .stall_ex_hz_i      (stall_ex_hz_i),
        .fwd_p1_hz_i        (fwd_p1_hz_i),
        .fwd_p2_hz_i        (fwd_p2_hz_i),
        .alu_res_mem_i      (alu_res_mem_i),
        .wr_data_wb_i       (wr_data_wb_i),
        .valid_ex_o         (valid_ex_o),
        .rs_ex_hz_o         (rs_ex_hz_o),
        .rt_ex_hz_o         (rt_ex_hz_o),
        .rd_ex_o            (rd_ex_o),
        .mem_to_reg_ex_hz_o (mem_to_reg_ex_hz_o),
        .reg_wr_ex_o        (reg_wr_ex_o),
        .mem_wr_ex_o        (mem_wr_ex_o),
        .alu_op_ex_o        (alu_op_ex_o),
        .op1_ex_o           (op1_ex_o),
        .op2_ex_o           (op2_ex_o),
        .store_data_ex_o    (store_data_ex_o),
        .bubble_cnt_o       (bubble_cnt_o),
        .stall_cnt_o        (stall_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One load vector: issue fields, forward inputs, and expected EX outputs after one edge.
    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic [3:0]  alu_op;
        logic        alu_src, mem_to_reg, mem_wr, reg_wr;
        logic [1:0]  fwd_p1, fwd_p2;
        logic [31:0] mem, wb;
        logic        e_reg_wr, e_mem_wr, e_m2r;
        logic [31:0] e_op1, e_op2, e_store;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_cnt();
        chk("bubble_cnt", bubble_cnt_o, exp_bubble);
        chk("stall_cnt", stall_cnt_o, exp_stall);
    endtask

    // Advance one edge, update the counter model from the controls seen at the edge.
    task automatic tick();
        @(posedge clk);
`ifdef ISS_EX_PERF_CNT_EN
        if (rst_n) begin
            if (flush_ex_hz_i)      exp_bubble = exp_bubble + 1;
            else if (stall_ex_hz_i) exp_stall  = exp_stall + 1;
        end
`endif
        #2;
    endtask

    task automatic drive(input vec_t v);
        valid_iss_i      = v.valid;
        rs_iss_i         = v.rs;
        rt_iss_i         = v.rt;
        rd_iss_i         = v.rd;
        rs_data_iss_i    = v.rs_data;
        rt_data_iss_i    = v.rt_data;
        imm_iss_i        = v.imm;
        alu_op_iss_i     = v.alu_op;
        alu_src_iss_i    = v.alu_src;
        mem_to_reg_iss_i = v.mem_to_reg;
        mem_wr_iss_i     = v.mem_wr;
        reg_wr_iss_i     = v.reg_wr;
        fwd_p1_hz_i      = v.fwd_p1;
        fwd_p2_hz_i      = v.fwd_p2;
        alu_res_mem_i    = v.mem;
        wr_data_wb_i     = v.wb;
    endtask

    task automatic chk_all_zero();
        chk("rst valid", {31'b0, valid_ex_o}, 0);
        chk("rst rs", {27'b0, rs_ex_hz_o}, 0);
        chk("rst rt", {27'b0, rt_ex_hz_o}, 0);
        chk("rst rd", {27'b0, rd_ex_o}, 0);
        chk("rst ctrl", {29'b0, mem_to_reg_ex_hz_o, reg_wr_ex_o, mem_wr_ex_o}, 0);
        chk("rst alu_op", {28'b0, alu_op_ex_o}, 0);
        chk("rst op1", op1_ex_o, 0);
        chk("rst op2", op2_ex_o, 0);
        chk("rst store", store_data_ex_o, 0);
        chk_cnt();
    endtask

    vec_t v;

    initial begin
        //        valid rs  rt  rd  rs_data       rt_data       imm           op
        //        src m2r mw rw fwd1 fwd2 mem wb | e_rw e_mw e_m2r e_op1 e_op2 e_store
        vecs[0] = '{1, 3, 4, 5, 32'h10, 32'h20, 32'h100, 4'h2,
                    0, 0, 0, 1, 2'b00, 2'b00, 32'h0, 32'h0,
                    1, 0, 0, 32'h10, 32'h20, 32'h20};
        vecs[1] = '{1, 5, 6, 7, 32'h1111, 32'h2222, 32'h0, 4'h2,
                    0, 0, 0, 1, 2'b10, 2'b01, 32'hDEAD, 32'hBEEF,
                    1, 0, 0, 32'hDEAD, 32'hBEEF, 32'hBEEF};
        vecs[2] = '{1, 8, 9, 10, 32'h44, 32'h33, 32'hFFFF_FFF0, 4'h6,
                    1, 0, 0, 1, 2'b11, 2'b11, 32'h5A5A, 32'hA5A5,
                    1, 0, 0, 32'h44, 32'hFFFF_FFF0, 32'h33};
        vecs[3] = '{0, 11, 12, 13, 32'h1, 32'h2, 32'h3, 4'h1,
                    0, 1, 1, 1, 2'b00, 2'b00, 32'h0, 32'h0,
                    0, 0, 0, 32'h1, 32'h2, 32'h2};
        vecs[4] = '{1, 14, 15, 0, 32'h1000, 32'h9, 32'h4, 4'h0,
                    1, 0, 1, 0, 2'b00, 2'b10, 32'h77, 32'h0,
                    0, 1, 0, 32'h1000, 32'h4, 32'h77};
        vecs[5] = '{1, 31, 2, 31, 32'h8, 32'hC, 32'h10, 4'hF,
                    1, 1, 0, 1, 2'b01, 2'b00, 32'h0, 32'hCAFE,
                    1, 0, 1, 32'hCAFE, 32'h10, 32'hC};

        // Reset asserted with busy inputs: every output reads 0.
        rst_n = 1'b0;
        flush_ex_hz_i = 1'b0;
        stall_ex_hz_i = 1'b0;
        v = vecs[0];
        v.fwd_p1 = 2'b00;
        v.fwd_p2 = 2'b00;
        drive(v);
        #3;
        chk_all_zero();
        rst_n = 1'b1;

        // Load vectors; the first one is the first edge after reset release.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("v%0d valid", i), {31'b0, valid_ex_o}, {31'b0, vecs[i].valid});
            chk($sformatf("v%0d rs", i), {27'b0, rs_ex_hz_o}, {27'b0, vecs[i].rs});
            chk($sformatf("v%0d rt", i), {27'b0, rt_ex_hz_o}, {27'b0, vecs[i].rt});
            chk($sformatf("v%0d rd", i), {27'b0, rd_ex_o}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d alu_op", i), {28'b0, alu_op_ex_o}, {28'b0, vecs[i].alu_op});
            chk($sformatf("v%0d reg_wr", i), {31'b0, reg_wr_ex_o}, {31'b0, vecs[i].e_reg_wr});
            chk($sformatf("v%0d mem_wr", i), {31'b0, mem_wr_ex_o}, {31'b0, vecs[i].e_mem_wr});
            chk($sformatf("v%0d m2r", i), {31'b0, mem_to_reg_ex_hz_o}, {31'b0, vecs[i].e_m2r});
            chk($sformatf("v%0d op1", i), op1_ex_o, vecs[i].e_op1);
            chk($sformatf("v%0d op2", i), op2_ex_o, vecs[i].e_op2);
            chk($sformatf("v%0d store", i), store_data_ex_o, vecs[i].e_store);
        end
        chk_cnt();

        // Stall with MEM forwarding: operand frozen at 0x55 while MEM moves on.
        v = vecs[0];
        v.rs = 5; v.rs_data = 32'h1; v.fwd_p1 = 2'b10; v.mem = 32'h55;
        drive(v);
        tick();
        chk("stl load op1", op1_ex_o, 32'h55);
        stall_ex_hz_i = 1'b1;
        rs_iss_i = 9;
        rs_data_iss_i = 32'hAAAA;
        #1;
        chk("stl c0 op1", op1_ex_o, 32'h55);
        tick();
        alu_res_mem_i = 32'h99;
        #1;
        chk("stl c1 op1", op1_ex_o, 32'h55);
        chk("stl c1 rs", {27'b0, rs_ex_hz_o}, 32'd5);
        fwd_p1_hz_i = 2'b01;
        wr_data_wb_i = 32'h123;
        #1;
        chk("stl c1 fwdsel ignored", op1_ex_o, 32'h55);
        tick();
        chk("stl c2 op1", op1_ex_o, 32'h55);
        tick();
        chk("stl c3 op1", op1_ex_o, 32'h55);
        chk_cnt();
        // Release: load clears the capture, so forwarding is live again.
        stall_ex_hz_i = 1'b0;
        fwd_p1_hz_i = 2'b10;
        tick();
        chk("stl rel rs", {27'b0, rs_ex_hz_o}, 32'd9);
        chk("stl rel op1", op1_ex_o, 32'h99);

        // Flush and stall together: bubble wins.
        v = vecs[0];
        v.reg_wr = 1; v.mem_to_reg = 1; v.mem_wr = 1;
        drive(v);
        flush_ex_hz_i = 1'b1;
        stall_ex_hz_i = 1'b1;
        tick();
        chk("fl valid", {31'b0, valid_ex_o}, 0);
        chk("fl reg_wr", {31'b0, reg_wr_ex_o}, 0);
        chk("fl mem_wr", {31'b0, mem_wr_ex_o}, 0);
        chk("fl m2r", {31'b0, mem_to_reg_ex_hz_o}, 0);
        chk_cnt();
        flush_ex_hz_i = 1'b0;
        stall_ex_hz_i = 1'b0;
        tick();
        chk("fl after valid", {31'b0, valid_ex_o}, 1);
        chk("fl after reg_wr", {31'b0, reg_wr_ex_o}, 1);

        // Reset mid-stall: outputs clear without an edge, then a normal load.
        v = vecs[0];
        v.rs_data = 32'h5555; v.rt_data = 32'h6666; v.imm = 32'h7777;
        drive(v);
        tick();
        stall_ex_hz_i = 1'b1;
        tick();
        #1;
        rst_n = 1'b0;
        exp_bubble = 0;
        exp_stall  = 0;
        #1;
        chk_all_zero();
        v = vecs[0];
        v.rs = 7; v.rs_data = 32'h70;
        drive(v);
        stall_ex_hz_i = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post rst valid", {31'b0, valid_ex_o}, 1);
        chk("post rst rs", {27'b0, rs_ex_hz_o}, 32'd7);
        chk("post rst op1", op1_ex_o, 32'h70);

        // Stall counter wrap (only meaningful with counters built in).
        stall_ex_hz_i = 1'b1;
`ifdef ISS_EX_PERF_CNT_EN
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        exp_stall = 32'hFFFF_FFFF;
        chk("wrap preload", stall_cnt_o, 32'hFFFF_FFFF);
`endif
        tick();
        chk("wrap stall_cnt", stall_cnt_o, exp_stall);
        chk_cnt();
        stall_ex_hz_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
